uart_tx_ctrl: RTL and testbench

- Serial transmit sequencer driven by the shared baud tick generator's 8x-oversampled `baud_tick` strobe.
- Accepts one byte per start handshake and serialises it LSB-first as an 8N1 frame on `tx`.
- Reports `tx_busy` while framing and pulses `tx_done` when the frame ends.
- Sits between the command/FIFO logic and the UART pin in the top-level UART path.

---
 rtl/uart_tx_ctrl.sv | 133 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8N1 serial transmit sequencer paced by an oversampled baud_tick.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit (8E1 frame).
// Every output is registered. Reset is synchronous and active high.
module uart_tx_ctrl #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    logic                 bit_end;
    logic [DATA_BITS-1:0] shift_d;

    // A bit period closes on the tick that completes OVERSAMPLE ticks
    always_comb begin
        bit_end = baud_tick && (tick_cnt_q == TW'(OVERSAMPLE - 1));
        shift_d = shift_q >> 1;
    end

    // Frame sequencer: state, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            // Ticks only advance the bit timer while a frame is on the line;
            // a tick coincident with acceptance is deliberately dropped.
            if (state_q != IDLE && baud_tick)
                tick_cnt_q <= bit_end ? '0 : tick_cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (start) begin
                        shift_q    <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_q   <= ^tx_data;
`endif
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            tx_q <= shift_d[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: frame-level reference model plus directed and random stimulus.
module tb_uart_tx_ctrl;
    localparam int OS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, tx_busy, tx_done;

    uart_tx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .start(start),
        .tx_data(tx_data), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int done_cnt = 0, busy_run = 0, last_len = 0;
    bit chk_en = 1'b0, tick_rand = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Whole frame as a bit list: start, data LSB first, [parity], stop
    function automatic logic [NB-1:0] frame(input logic [7:0] d);
        logic [NB-1:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    // Reference: a frame is NB*OS counted ticks; line shows bit (ticks/OS)
    logic          m_busy, m_tx, m_done;
    int            m_n;
    logic [NB-1:0] m_bits;
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_tx <= 1'b1; m_done <= 1'b0; m_n <= 0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (start) begin
                m_busy <= 1'b1; m_n <= 0; m_bits <= frame(tx_data); m_tx <= 1'b0;
            end else begin
                m_tx <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
            if (baud_tick) begin
                if (m_n + 1 == NB * OS) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_tx <= 1'b1;
                end else begin
                    m_tx <= m_bits[(m_n + 1) / OS];
                end
                m_n <= m_n + 1;
            end
        end
    end

    // Tick source: fixed every 4 clks, or random density
    initial begin
        int tdiv = 0;
        forever begin
            @(negedge clk);
            if (tick_rand) baud_tick = ($urandom_range(0, 2) == 0);
            else begin
                tdiv = (tdiv + 1) % 4;
                baud_tick = (tdiv == 0);
            end
        end
    end

    // Compare process: every cycle once out of reset
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("tx", tx, m_tx);
            chk("tx_busy", tx_busy, m_busy);
            chk("tx_done", tx_done, m_done);
            if (tx_done) done_cnt++;
            if (tx_busy) busy_run++;
            else begin
                if (busy_run != 0) last_len = busy_run;
                busy_run = 0;
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        start = 1'b1; tx_data = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge right after acceptance; samples each bit mid-period
    task automatic sample_frame(output logic [NB-1:0] s, input bit poke);
        repeat (16) @(negedge clk);
        for (int k = 0; k < NB; k++) begin
            s[k] = tx;
            if (poke && k == 3) begin
                start = 1'b1; tx_data = 8'hFF;
                @(negedge clk);
                start = 1'b0;
                repeat (31) @(negedge clk);
            end else begin
                repeat (32) @(negedge clk);
            end
        end
    endtask

    task automatic wait_idle(input string nm);
        int i = 0;
        while (tx_busy && i < 4000) begin @(negedge clk); i++; end
        chk(nm, tx_busy, 0);
    endtask

    task automatic wait_done(input string nm);
        int i = 0;
        do begin @(negedge clk); i++; end while (!tx_done && i < 4000);
        chk(nm, tx_done, 1);
    endtask

    task automatic chk_frame(input string nm, input logic [NB-1:0] s,
                             input logic [8:0] exp9, input bit par);
        chk({nm, "_bits"}, int'(s[8:0]), int'(exp9));
        chk({nm, "_stop"}, s[NB-1], 1);
`ifdef UART_TX_PARITY_EN
        chk({nm, "_par"}, s[9], par);
`else
        if (par) chk({nm, "_nopar_len"}, NB, 10);
`endif
    endtask

    initial begin
        logic [NB-1:0] s;
        int d0;

        // Reset and idle
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        repeat (100) @(negedge clk);
        chk("idle_tx", tx, 1);

        // Single frame 0x55
        d0 = done_cnt;
        send(8'h55);
        sample_frame(s, 1'b0);
        chk_frame("f55", s, 9'b0_1010_1010, 1'b0);
        wait_idle("f55_idle");
        chk("f55_done_cnt", done_cnt - d0, 1);
        chk("f55_len", int'(last_len >= NB*32-3 && last_len <= NB*32), 1);

        // Start ignored mid-frame
        d0 = done_cnt;
        send(8'hA3);
        sample_frame(s, 1'b1);
        chk_frame("fA3", s, 9'b1_0100_0110, 1'b0);
        wait_idle("fA3_idle");
        repeat (5) @(negedge clk);
        chk("fA3_done_cnt", done_cnt - d0, 1);

        // Back-to-back with start held high
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; tx_data = 8'h0F;
        wait_done("b2b_done1");
        chk("b2b_gap_tx", tx, 1);
        tx_data = 8'hF0;
        @(negedge clk);
        chk("b2b_restart_tx", tx, 0);
        chk("b2b_restart_busy", tx_busy, 1);
        wait_done("b2b_done2");
        start = 1'b0;
        @(negedge clk);
        chk("b2b_no_third", tx_busy, 0);
        chk("b2b_done_cnt", done_cnt - d0, 2);

        // Reset during data bit 3
        d0 = done_cnt;
        send(8'h00);
        repeat (16 + 32*4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_tx", tx, 1);
        chk("mrst_busy", tx_busy, 0);
        repeat (400) @(negedge clk);
        chk("mrst_no_done", done_cnt - d0, 0);
        send(8'h81);
        sample_frame(s, 1'b0);
        chk_frame("f81", s, 9'b1_0000_0010, 1'b0);
        wait_idle("f81_idle");

        // Parity values and frame length
        send(8'h07);
        sample_frame(s, 1'b0);
        chk_frame("f07", s, 9'b0_0000_1110, 1'b1);
        wait_idle("f07_idle");
        chk("f07_len", int'(last_len >= NB*32-3 && last_len <= NB*32), 1);
        send(8'h03);
        sample_frame(s, 1'b0);
        chk_frame("f03", s, 9'b0_0000_0110, 1'b0);
        wait_idle("f03_idle");

        // Random traffic, random tick density, rare resets
        tick_rand = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 9) == 0);
            tx_data = 8'($urandom);
            rst     = ($urandom_range(0, 1499) == 0);
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        wait_idle("rand_idle");
        tick_rand = 1'b0;
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
